// File: rtl/rect_hit_tracker_pkg.sv
// Shared types and screen defaults for the rectangle hit tracker.
// Covers the load FSM state encoding and the per-rectangle origin record.
package rect_hit_tracker_pkg;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_ADDR_W   = 19;
  localparam int COORD_W      = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_WRITE   = 2'd2
  } load_state_t;

  typedef struct packed {
    logic               on;
    logic [COORD_W-1:0] ox;
    logic [COORD_W-1:0] oy;
  } rect_t;

endpackage

// File: rtl/rect_hit_tracker_if.sv
// Origin-load port: ready/valid request carrying a linear pixel address,
// plus the range-error pulse returned by the tracker.
interface rect_hit_tracker_if #(
  parameter int ADDR_W = 19,
  parameter int IDX_W  = 2
);
  logic              load_valid;
  logic              load_ready;
  logic [IDX_W-1:0]  load_idx;
  logic [ADDR_W-1:0] load_addr;
  logic              load_on;
  logic              load_err;

  modport master (
    output load_valid, load_idx, load_addr, load_on,
    input  load_ready, load_err
  );

  modport slave (
    input  load_valid, load_idx, load_addr, load_on,
    output load_ready, load_err
  );
endinterface

// File: rtl/rect_hit_tracker_addr_to_xy.sv
// Serial subtract divider: splits a linear pixel address into (x, y) by
// removing one line width per cycle; done is high on the cycle the result is ready.
module addr_to_xy
  import rect_hit_tracker_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic               o_done,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y
);

  logic               r_busy;
  logic [ADDR_W-1:0]  r_rem;
  logic [COORD_W-1:0] r_q;
  logic               w_ge;

  assign w_ge = (r_rem >= ADDR_W'(SCREEN_W));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_busy <= 1'b0;
      r_rem  <= '0;
      r_q    <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_rem  <= i_addr;
      r_q    <= '0;
    end else if (r_busy) begin
      if (w_ge) begin
        r_rem <= r_rem - ADDR_W'(SCREEN_W);
        r_q   <= r_q + COORD_W'(1);
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  // Remainder and quotient hold after completion so the writer can pick them up.
  assign o_done = r_busy & ~w_ge;
  assign o_x    = r_rem[COORD_W-1:0];
  assign o_y    = r_q;

endmodule

// File: rtl/rect_hit_tracker.sv
// Multi-rectangle hit detector: raster x/y counters, double-buffered rectangle
// origins swapped at frame start, per-rectangle comparators and a priority encoder.
module rect_hit_tracker
  import rect_hit_tracker_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RECT = 4,
  parameter int IDX_W    = 2,
  parameter int RECT_W   = 40,
  parameter int RECT_H   = 50
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_frame_start,
  input  logic                i_pix_valid,
  rect_hit_tracker_if.slave   io_load,
  output logic                o_hit_valid,
  output logic [NUM_RECT-1:0] o_hit,
  output logic                o_hit_any,
  output logic [IDX_W-1:0]    o_hit_idx
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(SCREEN_W * SCREEN_H);
  localparam int                CMP_W      = ADDR_W + 1;

  load_state_t        r_state, w_state_next;
  logic               w_accept, w_range_err, w_start, w_write;
  logic [IDX_W-1:0]   r_idx;
  logic               r_on, r_err;
  logic               w_div_done;
  logic [COORD_W-1:0] w_div_x, w_div_y;
  rect_t              w_new;

  assign w_accept    = (r_state == ST_IDLE) & io_load.load_valid;
  assign w_range_err = io_load.load_on & (io_load.load_addr >= ADDR_LIMIT);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next       = r_state;
    w_start            = 1'b0;
    w_write            = 1'b0;
    io_load.load_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        io_load.load_ready = 1'b1;
        if (io_load.load_valid) begin
          if (!io_load.load_on) begin
            w_state_next = ST_WRITE;
          end else if (!w_range_err) begin
            w_state_next = ST_CONVERT;
            w_start      = 1'b1;
          end
        end
      end
      ST_CONVERT: if (w_div_done) w_state_next = ST_WRITE;
      ST_WRITE: begin
        w_write      = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_on    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_accept & w_range_err;
      if (w_accept) begin
        r_idx <= io_load.load_idx;
        r_on  <= io_load.load_on;
      end
    end
  end

  assign io_load.load_err = r_err;

  addr_to_xy #(.SCREEN_W(SCREEN_W), .ADDR_W(ADDR_W)) u_addr_to_xy (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_start (w_start),
    .i_addr  (io_load.load_addr),
    .o_done  (w_div_done),
    .o_x     (w_div_x),
    .o_y     (w_div_y)
  );

  // A disable writes origin 0 rather than whatever the divider last produced.
  always_comb begin
    w_new    = '0;
    w_new.on = r_on;
    if (r_on) begin
      w_new.ox = w_div_x;
      w_new.oy = w_div_y;
    end
  end

  rect_t r_shadow [NUM_RECT];
  rect_t r_active [NUM_RECT];
  rect_t w_shadow_next [NUM_RECT];
  rect_t w_cur [NUM_RECT];

  // The frame_start pixel already belongs to the new frame, so it sees the swapped set.
  always_comb begin
    for (int i = 0; i < NUM_RECT; i++) begin
      w_shadow_next[i] = (w_write && (r_idx == IDX_W'(i))) ? w_new : r_shadow[i];
      w_cur[i]         = i_frame_start ? w_shadow_next[i] : r_active[i];
    end
  end

  // NOTE: these are a few flop-based entries, not a RAM macro, so resetting them is legitimate.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_RECT; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      r_shadow <= w_shadow_next;
      if (i_frame_start) r_active <= w_shadow_next;
    end
  end

  logic [COORD_W-1:0] r_x, r_y, w_px, w_py;

  assign w_px = i_frame_start ? '0 : r_x;
  assign w_py = i_frame_start ? '0 : r_y;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_pix_valid) begin
      if (w_px == COORD_W'(SCREEN_W - 1)) begin
        r_x <= '0;
        r_y <= (w_py == COORD_W'(SCREEN_H - 1)) ? '0 : w_py + COORD_W'(1);
      end else begin
        r_x <= w_px + COORD_W'(1);
        r_y <= w_py;
      end
    end else if (i_frame_start) begin
      r_x <= '0;
      r_y <= '0;
    end
  end

  logic [NUM_RECT-1:0] w_hit;
  logic [IDX_W-1:0]    w_hit_idx;

  for (genvar g = 0; g < NUM_RECT; g++) begin : g_cmp
    logic [CMP_W-1:0] w_x, w_y, w_ox, w_oy;
    assign w_x  = CMP_W'(w_px);
    assign w_y  = CMP_W'(w_py);
    assign w_ox = CMP_W'(w_cur[g].ox);
    assign w_oy = CMP_W'(w_cur[g].oy);
    assign w_hit[g] = w_cur[g].on
                    & (w_x >= w_ox) & (w_x < w_ox + CMP_W'(RECT_W))
                    & (w_y >= w_oy) & (w_y < w_oy + CMP_W'(RECT_H));
  end

  always_comb begin
    w_hit_idx = '0;
    for (int i = NUM_RECT - 1; i >= 0; i--) begin
      if (w_hit[i]) w_hit_idx = IDX_W'(i);
    end
  end

  logic                r_hit_valid, r_hit_any;
  logic [NUM_RECT-1:0] r_hit;
  logic [IDX_W-1:0]    r_hit_idx;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_hit_valid <= 1'b0;
      r_hit       <= '0;
      r_hit_any   <= 1'b0;
      r_hit_idx   <= '0;
    end else begin
      r_hit_valid <= i_pix_valid;
      if (i_pix_valid) begin
        r_hit     <= w_hit;
        r_hit_any <= |w_hit;
        r_hit_idx <= w_hit_idx;
      end
    end
  end

  assign o_hit_valid = r_hit_valid;
  assign o_hit       = r_hit;
  assign o_hit_any   = r_hit_any;
  assign o_hit_idx   = r_hit_idx;

endmodule
